// File: rtl/adder_pipe_pkg.sv
// Shared defaults and configuration check for the pipelined adder/subtractor.
package adder_pipe_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Legal when every stage gets an equal, non-empty slice of the operands.
  function automatic bit slice_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple of SLICE full adders; one of these per pipeline stage.
module adder_slice
  import adder_pipe_pkg::*;
#(
  parameter int SLICE = DEFAULT_WIDTH / DEFAULT_STAGES
) (
  output logic [SLICE-1:0] s,
  output logic             c_out,
  input  logic             c_in,
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y
);

  // Carries live in per-bit generate scopes so the chain is not one self-feeding vector.
  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    logic ci, co;
    if (i == 0) begin : g_first
      assign ci = c_in;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    complete_adder u_fa (
      .s    (s[i]),
      .c_out(co),
      .c_in (ci),
      .x    (x[i]),
      .y    (y[i])
    );
  end

  assign c_out = g_fa[SLICE-1].co;

endmodule

// File: rtl/complete_adder.sv
// One-bit full adder, the building block of each pipeline slice.
module complete_adder (
  output logic s,
  output logic c_out,
  input  logic c_in,
  input  logic x,
  input  logic y
);

  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one slice rippled per stage, valid/ready on
// both sides with a combinational, bubble-free ready chain.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  if (!slice_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] vld, vld_nxt, adv, load;
  logic [STAGES:0]   vld_in;

  // vld_in[k] is the valid bit arriving at stage k (stage 0 sees in_valid).
  assign vld_in = {vld, in_valid};

  // A stage advances if any stage downstream of it has a hole, or the consumer drains.
  always_comb begin
    adv     = '0;
    load    = '0;
    vld_nxt = vld;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k + 1; j < STAGES; j++)
        if (!vld[j]) adv[k] = 1'b1;
      load[k] = !vld[k] || adv[k];
      if (load[k]) vld_nxt[k] = vld_in[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else        vld <= vld_nxt;
  end

  assign in_ready  = load[0];
  assign out_valid = vld[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;                // sum bits already produced upstream
    localparam int UP = WIDTH - (k + 1) * SLICE;  // operand bits still pending after this stage

    logic [WIDTH-LO-1:0] xi, yi;
    logic                ci;
    logic [LO+SLICE-1:0] sn, sr;
    logic [SLICE-1:0]    slice_s;
    logic                slice_c, cr;

    if (k == 0) begin : g_in
      // Zero idle operands so nothing undefined ever enters the datapath.
      assign xi = in_valid ? x : '0;
      assign yi = in_valid ? (y ^ {WIDTH{sub}}) : '0;
      assign ci = in_valid & (c_in ^ sub);
      assign sn = slice_s;
    end else begin : g_link
      assign xi = g_stage[k-1].g_up.xr;
      assign yi = g_stage[k-1].g_up.yr;
      assign ci = g_stage[k-1].cr;
      assign sn = {slice_s, g_stage[k-1].sr};
    end

    adder_slice #(.SLICE(SLICE)) u_slice (
      .s    (slice_s),
      .c_out(slice_c),
      .c_in (ci),
      .x    (xi[SLICE-1:0]),
      .y    (yi[SLICE-1:0])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= '0;
        cr <= 1'b0;
      end else if (load[k]) begin
        sr <= sn;
        cr <= slice_c;
      end
    end

    if (UP > 0) begin : g_up
      logic [UP-1:0] xr, yr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          xr <= '0;
          yr <= '0;
        end else if (load[k]) begin
          xr <= xi[WIDTH-LO-1:SLICE];
          yr <= yi[WIDTH-LO-1:SLICE];
        end
      end
    end else begin : g_out
      // Last stage holds the operand MSBs, so overflow is resolved here and registered.
      logic ovf_n, ovf_r;
      assign ovf_n = (xi[SLICE-1] == yi[SLICE-1]) && (slice_s[SLICE-1] != xi[SLICE-1]);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovf_r <= 1'b0;
        else if (load[k]) ovf_r <= ovf_n;
      end
    end
  end

  assign s     = g_stage[STAGES-1].sr;
  assign c_out = g_stage[STAGES-1].cr;
  assign ovf   = g_stage[STAGES-1].g_out.ovf_r;

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: expected results queued on input transfer,
// popped and compared on output transfer.
module tb_adder_pipe;

  localparam int W  = 16;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [W-1:0] x, y, s;

  int vectors = 0, miscompares = 0, accepts = 0, pops = 0;
  logic [17:0] sb_q[$];

  adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: plain integer arithmetic. Returns {c_out, s, ovf}.
  function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic ci, input logic sb);
    int ua, ub, sa, sbv, full, sres;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    if (!sb) begin
      full = ua + ub + int'(ci);
      sres = sa + sbv + int'(ci);
    end else begin
      full = ua - ub - int'(ci) + 65536;
      sres = sa - sbv - int'(ci);
    end
    return {full[16:0], (sres > 32767) || (sres < -32768)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: transfers complete at the next rising edge, so sample on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb_q.push_back(model(x, y, c_in, sub));
        accepts++;
      end
      if (out_valid && out_ready) begin
        pops++;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got s=%h c_out=%b ovf=%b with empty scoreboard",
                   s, c_out, ovf);
        end else begin
          chk("result", {14'd0, c_out, s, ovf}, {14'd0, sb_q.pop_front()});
        end
      end
    end
  end

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners[6];
    corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single op into an empty pipe; checks latency and the directed expected value.
  task automatic lat_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input logic sb, input logic [17:0] exp, input string name);
    int lat;
    x = a; y = b; c_in = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk({name, "_latency"}, 32'(lat), 32'(ST));
    chk(name, {14'd0, c_out, s, ovf}, {14'd0, exp});
    tick();
  endtask

  initial begin
    logic [W-1:0] held_s;
    bit           held;
    int           a0, p0, n;

    // Reset with in_valid asserted: nothing may be accepted or emitted.
    rst_n = 1'b0; in_valid = 1'b1; x = W'($urandom); y = W'($urandom);
    c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_cout_ovf", {30'd0, c_out, ovf}, 32'd0);
    tick();
    in_valid = 1'b0; rst_n = 1'b1;
    repeat (2) tick();

    lat_check(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 16'h0000, 1'b0}, "add_wrap");
    lat_check(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 16'h7FFF, 1'b1}, "sub_ovf");
    lat_check(16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 16'hFFFE, 1'b0}, "sub_borrow");
    lat_check(16'h0003, 16'h0005, 1'b1, 1'b1, {1'b0, 16'hFFFD, 1'b0}, "sub_borrow_in");
    lat_check(16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 16'h8000, 1'b1}, "add_cin_ovf");

    // Back-to-back: 16 ops, expect 16 results within the minimum window.
    a0 = accepts; p0 = pops; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x = pick(); y = pick(); c_in = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (ST - 1) tick();
    @(negedge clk);
    #1;
    chk("b2b_accepts", 32'(accepts - a0), 32'd16);
    chk("b2b_results", 32'(pops - p0), 32'd16);
    tick();

    // Backpressure: consumer stalls for 6 cycles while the producer keeps offering.
    a0 = accepts; out_ready = 1'b0; held = 1'b0; held_s = '0;
    for (int i = 0; i < 6; i++) begin
      x = pick(); y = pick(); c_in = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      @(negedge clk);
      if (out_valid && !held) begin
        held = 1'b1;
        held_s = s;
      end
      tick();
    end
    @(negedge clk);
    chk("bp_accepts", 32'(accepts - a0), 32'(ST));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_s_stable", 32'(s), 32'(held_s));
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (ST + 4) tick();
    chk("bp_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-flight: in-flight ops are discarded, no stale result afterwards.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = pick(); y = pick(); c_in = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    repeat (2) tick();
    in_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (ST + 4) tick();

    // Random traffic with random valid/ready.
    for (int i = 0; i < 400; i++) begin
      x = pick(); y = pick(); c_in = 1'($urandom); sub = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("final_drained", 32'(sb_q.size()), 32'd0);
    chk("final_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
